// File: rtl/func_job_sequencer_if.sv
// Purpose: bundles the operand input, result output, func-unit and level
//          signals of func_job_sequencer into one interface.
// Ports (signals):
//   in_valid_i/in_ready_o/in_a_bi/in_b_bi  operand pair handshake
//   out_valid_o/out_ready_i/out_y_bo       result handshake
//   fu_start_o/fu_a_bo/fu_b_bo             job issue to func
//   fu_busy_i/fu_y_bi                      status/result from func
//   level_o                                operand FIFO occupancy
// slave modport is the sequencer side; master modport is its environment.
interface func_job_sequencer_if #(
   parameter int unsigned AW = 2
);
   logic          in_valid_i;
   logic          in_ready_o;
   logic [7:0]    in_a_bi;
   logic [7:0]    in_b_bi;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [7:0]    out_y_bo;
   logic          fu_start_o;
   logic [7:0]    fu_a_bo;
   logic [7:0]    fu_b_bo;
   logic          fu_busy_i;
   logic [7:0]    fu_y_bi;
   logic [AW:0]   level_o;

   modport slave (
      input  in_valid_i, in_a_bi, in_b_bi, out_ready_i, fu_busy_i, fu_y_bi,
      output in_ready_o, out_valid_o, out_y_bo, fu_start_o, fu_a_bo, fu_b_bo,
             level_o
   );

   modport master (
      output in_valid_i, in_a_bi, in_b_bi, out_ready_i, fu_busy_i, fu_y_bi,
      input  in_ready_o, out_valid_o, out_y_bo, fu_start_o, fu_a_bo, fu_b_bo,
             level_o
   );
endinterface

// File: rtl/func_job_sequencer.sv
// Purpose: buffers (a,b) operand pairs in a FIFO, issues them one at a time
//          to the func unit (start/busy handshake) and returns each result
//          in acceptance order over valid/ready.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    func_job_sequencer_if.slave: operand input, result output,
//          func-unit interface and FIFO level
module func_job_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   func_job_sequencer_if.slave     bus
);

   localparam int unsigned LW = AW + 1;
   localparam int unsigned DW = 16;
   localparam logic [AW:0] LEVEL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE
   } state_e;

   state_e                     state_q, state_d;
   logic [DEPTH-1:0][DW-1:0]   mem_q, mem_d;
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [AW:0]                level_q, level_d;
   logic                       out_valid_q, out_valid_d;
   logic [7:0]                 out_y_q, out_y_d;
   logic                       fu_start_q, fu_start_d;
   logic [7:0]                 fu_a_q, fu_a_d;
   logic [7:0]                 fu_b_q, fu_b_d;

   logic                       pop_c;
   logic                       push_c;
   logic                       in_ready_c;

   // Pop only when no result is pending, so at most one job is ever in flight.
   assign pop_c      = (state_q == ST_IDLE) && (level_q != '0) && !out_valid_q;
   // A pop in the same cycle frees a slot, so a full FIFO may still accept.
   assign in_ready_c = (level_q != LEVEL_FULL) || pop_c;
   assign push_c     = bus.in_valid_i && in_ready_c;

   // Next-state logic for FIFO, FSM and output registers.
   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      fu_start_d  = 1'b0;
      fu_a_d      = fu_a_q;
      fu_b_d      = fu_b_q;

      if (push_c) begin
         mem_d[wr_ptr_q] = {bus.in_a_bi, bus.in_b_bi};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (out_valid_q && bus.out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop_c) begin
               fu_a_d     = mem_q[rd_ptr_q][15:8];
               fu_b_d     = mem_q[rd_ptr_q][7:0];
               fu_start_d = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (bus.fu_busy_i) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.fu_busy_i) begin
               out_y_d     = bus.fu_y_bi;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         fu_start_q  <= 1'b0;
         fu_a_q      <= '0;
         fu_b_q      <= '0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         fu_start_q  <= fu_start_d;
         fu_a_q      <= fu_a_d;
         fu_b_q      <= fu_b_d;
      end
   end

   assign bus.in_ready_o  = in_ready_c;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_y_bo    = out_y_q;
   assign bus.fu_start_o  = fu_start_q;
   assign bus.fu_a_bo     = fu_a_q;
   assign bus.fu_b_bo     = fu_b_q;
   assign bus.level_o     = level_q;

   // func-unit handshake protocol checks.
   a_start_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
      !(fu_start_q && bus.fu_busy_i));
   a_start_single: assert property (@(posedge clk_i) disable iff (rst_i)
      fu_start_q |=> !fu_start_q);

endmodule

// File: tb/tb_func_job_sequencer.sv
// Purpose: self-checking bench for func_job_sequencer with a behavioural
//          func unit (busy for several cycles, y = cbrt(a + sqrt(b))).
module tb_func_job_sequencer;

   logic clk;
   logic rst;

   func_job_sequencer_if #(.AW(2)) bus ();

   func_job_sequencer #(.DEPTH(4), .AW(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
   } vec_t;

   vec_t vecs[8];

   // Behavioural func unit: busy rises the cycle after start, stays up 4 cycles.
   function automatic int ref_y(input int a, input int b);
      int s = 0;
      int c = 0;
      int t;
      while ((s + 1) * (s + 1) <= b) s++;
      t = (a + s) % 256;
      while ((c + 1) * (c + 1) * (c + 1) <= t) c++;
      return c;
   endfunction

   int         fu_cnt;
   logic [7:0] fu_res;

   always @(posedge clk) begin
      if (rst) begin
         bus.fu_busy_i <= 1'b0;
         bus.fu_y_bi   <= '0;
         fu_cnt        <= 0;
         fu_res        <= '0;
      end else if (bus.fu_busy_i) begin
         if (fu_cnt == 0) begin
            bus.fu_busy_i <= 1'b0;
            bus.fu_y_bi   <= fu_res;
         end else begin
            fu_cnt <= fu_cnt - 1;
         end
      end else if (bus.fu_start_o) begin
         bus.fu_busy_i <= 1'b1;
         fu_cnt        <= 3;
         fu_res        <= 8'(ref_y(int'(bus.fu_a_bo), int'(bus.fu_b_bo)));
      end
   end

   // Result collector and start counter.
   logic [7:0] got_q[$];
   int         starts;
   int         ready_bad;

   always @(posedge clk) begin
      if (rst) begin
         starts <= 0;
      end else begin
         if (bus.fu_start_o) starts <= starts + 1;
         if (bus.out_valid_o && bus.out_ready_i) got_q.push_back(bus.out_y_bo);
      end
   end

   // in_ready may only be low while the FIFO is full.
   initial ready_bad = 0;
   always @(negedge clk) begin
      if (!rst && !bus.in_ready_o && bus.level_o != 3'd4) ready_bad++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.in_valid_i  = 1'b0;
      bus.in_a_bi     = '0;
      bus.in_b_bi     = '0;
      bus.out_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [7:0] a, input logic [7:0] b);
      bit ok = 1'b0;
      bus.in_valid_i = 1'b1;
      bus.in_a_bi    = a;
      bus.in_b_bi    = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.in_ready_o;
         @(negedge clk);
      end
      bus.in_valid_i = 1'b0;
      chk("push_accepted", int'(ok), 1);
   endtask

   task automatic wait_got(input int n);
      for (int i = 0; i < 1000 && got_q.size() < n; i++) @(negedge clk);
      chk("result_count", got_q.size(), n);
   endtask

   task automatic wait_sig(input string name, input int which);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         case (which)
            0:       seen = bus.fu_start_o;
            1:       seen = bus.out_valid_o;
            default: seen = bus.fu_busy_i;
         endcase
         if (!seen) @(negedge clk);
      end
      chk(name, int'(seen), 1);
   endtask

   initial begin
      vecs[0] = '{a: 8'd1,   b: 8'd16,  y: 8'd1};
      vecs[1] = '{a: 8'd23,  b: 8'd16,  y: 8'd3};
      vecs[2] = '{a: 8'd60,  b: 8'd16,  y: 8'd4};
      vecs[3] = '{a: 8'd0,   b: 8'd0,   y: 8'd0};
      vecs[4] = '{a: 8'd255, b: 8'd255, y: 8'd2};
      vecs[5] = '{a: 8'd200, b: 8'd100, y: 8'd5};
      vecs[6] = '{a: 8'd7,   b: 8'd1,   y: 8'd2};
      vecs[7] = '{a: 8'd124, b: 8'd1,   y: 8'd5};

      @(negedge clk);
      do_reset();

      // Reset values.
      chk("rst_in_ready",  int'(bus.in_ready_o), 1);
      chk("rst_out_valid", int'(bus.out_valid_o), 0);
      chk("rst_out_y",     int'(bus.out_y_bo), 0);
      chk("rst_fu_start",  int'(bus.fu_start_o), 0);
      chk("rst_fu_a",      int'(bus.fu_a_bo), 0);
      chk("rst_fu_b",      int'(bus.fu_b_bo), 0);
      chk("rst_level",     int'(bus.level_o), 0);

      // Single job (4,16) -> 2.
      push(8'd4, 8'd16);
      chk("t1_no_early_start", int'(bus.fu_start_o), 0);
      wait_sig("t1_start_seen", 0);
      chk("t1_fu_a", int'(bus.fu_a_bo), 4);
      chk("t1_fu_b", int'(bus.fu_b_bo), 16);
      wait_sig("t1_valid_seen", 1);
      chk("t1_out_y", int'(bus.out_y_bo), 2);
      chk("t1_fu_a_held", int'(bus.fu_a_bo), 4);
      chk("t1_starts", starts, 1);
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      chk("t1_valid_cleared", int'(bus.out_valid_o), 0);

      // Burst of vectors with a ready consumer: results in order.
      got_q.delete();
      for (int i = 0; i < 8; i++) push(vecs[i].a, vecs[i].b);
      wait_got(8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size()) chk($sformatf("t2_y[%0d]", i), int'(got_q[i]), int'(vecs[i].y));
      end
      chk("t2_ready_only_when_full", ready_bad, 0);

      // Fill FIFO with the consumer stalled.
      do_reset();
      got_q.delete();
      push(8'd4, 8'd16);
      push(8'd1, 8'd16);
      push(8'd23, 8'd16);
      push(8'd60, 8'd16);
      push(8'd0, 8'd0);
      repeat (20) @(negedge clk);
      chk("t3_out_valid", int'(bus.out_valid_o), 1);
      chk("t3_out_y", int'(bus.out_y_bo), 2);
      chk("t3_level", int'(bus.level_o), 4);
      chk("t3_in_ready", int'(bus.in_ready_o), 0);
      chk("t3_starts", starts, 1);

      // Pending result held for 10 cycles, no new start.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t6_out_y_stable", int'(bus.out_y_bo), 2);
         chk("t6_no_start", int'(bus.fu_start_o), 0);
      end
      chk("t6_starts", starts, 1);

      // Full FIFO: take result and push in the pop cycle.
      bus.out_ready_i = 1'b1;
      push(8'd7, 8'd1);
      chk("t4_level_full", int'(bus.level_o), 4);
      wait_got(6);
      begin
         logic [7:0] exp4[6];
         exp4 = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd0, 8'd2};
         for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) chk($sformatf("t4_y[%0d]", i), int'(got_q[i]), int'(exp4[i]));
         end
      end

      // Reset during WAIT_DONE of (60,16).
      do_reset();
      bus.out_ready_i = 1'b1;
      push(8'd60, 8'd16);
      push(8'd1, 8'd16);
      wait_sig("t5_busy_seen", 2);
      @(negedge clk);
      chk("t5_still_busy", int'(bus.fu_busy_i), 1);
      rst = 1'b1;
      got_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("t5_out_valid", int'(bus.out_valid_o), 0);
      chk("t5_level", int'(bus.level_o), 0);
      chk("t5_busy_cleared", int'(bus.fu_busy_i), 0);
      push(8'd23, 8'd16);
      wait_got(1);
      if (got_q.size() > 0) chk("t5_y", int'(got_q[0]), 3);
      repeat (30) @(negedge clk);
      chk("t5_no_stale", got_q.size(), 1);
      chk("final_ready_only_when_full", ready_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
